hazard_ctrl: RTL and testbench

Pipeline hazard scheduler for the 3-stage RV32I core (S1 fetch/decode, S2 execute, S3 memory/writeback). It tracks destination registers of the instructions in S2 and S3 and registers the S2 operand-source selects (`rs1_sel`/`rs2_sel`) that the S2 control decode currently ties to regfile. It also sequences load-use stalls and branch/jump flushes, driving PC hold, S1 hold and S2 bubble insertion.

---
 rtl/hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard scheduler for the 3-stage RV32I core: S2/S3 destination scoreboard, registered
// S2 operand selects, load-use stall and redirect flush. Define HAZARD_LOAD_FWD_EN to forward load data.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_s1,
  input  logic        s1_valid,
  input  logic        redirect_s2,
  output logic [1:0]  rs1_sel,
  output logic [1:0]  rs2_sel,
  output logic        pc_stall,
  output logic        s1_stall,
  output logic        s2_bubble,
  output logic        s1_flush
);
  localparam int NUM_SRC = 2;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ARI_I  = 7'b0010011;
  localparam logic [6:0] OP_ARI_R  = 7'b0110011;
  localparam logic [6:0] OP_CSR    = 7'b1110011;

  localparam logic [1:0] SEL_WB    = 2'b00;
  localparam logic [1:0] SEL_LATCH = 2'b01;
  localparam logic [1:0] SEL_RF    = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic       is_load;
  } sb_entry_t;

  typedef enum logic [1:0] {INIT, RUN, LU_STALL} state_t;

  state_t                        state;
  sb_entry_t                     sb_s1, sb_s2, sb_s3;
  logic [6:0]                    opcode;
  logic [4:0]                    rd_idx;
  logic [NUM_SRC-1:0][4:0]       rs_idx;
  logic [NUM_SRC-1:0]            rs_used, hit_s2, hit_s3, load_hit;
  logic [NUM_SRC-1:0][1:0]       sel_nxt, sel_q;
  logic                          rd_wen, is_load, lu_hazard;

  assign opcode    = inst_s1[6:0];
  assign rd_idx    = inst_s1[11:7];
  assign rs_idx[0] = inst_s1[19:15];
  assign rs_idx[1] = inst_s1[24:20];
  assign is_load   = (opcode == OP_LOAD);

  wire unused_inst = ^{inst_s1[31:25], inst_s1[13:12]};

  always_comb begin
    rd_wen  = 1'b0;
    rs_used = '0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL: rd_wen = 1'b1;
      OP_JALR, OP_LOAD, OP_ARI_I: begin
        rd_wen     = 1'b1;
        rs_used[0] = 1'b1;
      end
      OP_BRANCH, OP_STORE: rs_used = 2'b11;
      OP_ARI_R: begin
        rd_wen  = 1'b1;
        rs_used = 2'b11;
      end
      // CSR immediate forms (funct3[2] set) carry a zimm, not rs1
      OP_CSR: begin
        rd_wen     = 1'b1;
        rs_used[0] = ~inst_s1[14];
      end
      default: ;
    endcase
    if (rd_idx == 5'd0) rd_wen = 1'b0;
    if (!s1_valid) rs_used = '0;
  end

  assign sb_s1 = '{valid:   s1_valid,
                   rd:      rd_idx,
                   wen:     rd_wen & s1_valid,
                   is_load: is_load & s1_valid};

  // During LU_STALL the load sits in S3 and its data arrives on the S3 path, hence 00
  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_src
      assign hit_s2[g]   = rs_used[g] && (rs_idx[g] != 5'd0) &&
                           sb_s2.valid && sb_s2.wen && (sb_s2.rd == rs_idx[g]);
      assign hit_s3[g]   = rs_used[g] && (rs_idx[g] != 5'd0) &&
                           sb_s3.valid && sb_s3.wen && (sb_s3.rd == rs_idx[g]);
      assign load_hit[g] = hit_s2[g] && sb_s2.is_load;
      assign sel_nxt[g]  = hit_s2[g] ? SEL_WB :
                           hit_s3[g] ? ((state == LU_STALL) ? SEL_WB : SEL_LATCH) :
                           SEL_RF;
    end
  endgenerate

`ifdef HAZARD_LOAD_FWD_EN
  assign lu_hazard = 1'b0;
  wire unused_load_hit = |load_hit;
`else
  assign lu_hazard = |load_hit;
`endif

  always_comb begin
    pc_stall  = 1'b0;
    s1_stall  = 1'b0;
    s2_bubble = 1'b0;
    s1_flush  = 1'b0;
    case (state)
      INIT: s2_bubble = 1'b1;
      RUN: begin
        if (redirect_s2) begin
          s1_flush  = 1'b1;
          s2_bubble = 1'b1;
        end else if (lu_hazard) begin
          pc_stall  = 1'b1;
          s1_stall  = 1'b1;
          s2_bubble = 1'b1;
        end
      end
      LU_STALL: begin
        if (redirect_s2) begin
          s1_flush  = 1'b1;
          s2_bubble = 1'b1;
        end
      end
      default: s2_bubble = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= INIT;
      sb_s2 <= '0;
      sb_s3 <= '0;
      sel_q <= {NUM_SRC{SEL_RF}};
    end else begin
      sb_s3 <= sb_s2;
      sb_s2 <= s2_bubble ? '0 : sb_s1;
      case (state)
        INIT:    state <= RUN;
        RUN:     if (!redirect_s2 && lu_hazard) state <= LU_STALL;
        default: state <= RUN;
      endcase
      // A bubble that is not a stall (INIT or redirect) leaves nothing real in S2
      if (s2_bubble && !s1_stall) sel_q <= {NUM_SRC{SEL_RF}};
      else if (!s1_stall)         sel_q <= sel_nxt;
    end
  end

  assign rs1_sel = sel_q[0];
  assign rs2_sel = sel_q[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table for the listed scenarios, then random
// instruction streams checked against a pipeline-occupancy reference model.
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst_s1 = '0;
  logic        s1_valid = 1'b0;
  logic        redirect_s2 = 1'b0;
  logic [1:0]  rs1_sel, rs2_sel;
  logic        pc_stall, s1_stall, s2_bubble, s1_flush;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .inst_s1(inst_s1), .s1_valid(s1_valid),
    .redirect_s2(redirect_s2), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
    .pc_stall(pc_stall), .s1_stall(s1_stall), .s2_bubble(s2_bubble),
    .s1_flush(s1_flush)
  );

  always #5 clk = ~clk;

`ifdef HAZARD_LOAD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          r;
    logic [31:0] ins;
    bit          v;
    bit          redir;
    logic [1:0]  s1, s2;
    bit          pc, st, bub, fl;
  } vec_t;

  vec_t tbl[$];

  // Reference model: what sits in S2/S3 (destination or -1) and the selects latched for S2
  int         m_mode = 0;  // 0 reset, 1 running, 2 one-cycle load-use stall
  int         m_d2 = -1, m_d3 = -1;
  bit         m_l2 = 1'b0;
  logic [1:0] m_sel0 = 2'd2, m_sel1 = 2'd2;
  bit         e_pc, e_st, e_bub, e_fl, e_hz;
  int         c_dst;
  bit         c_ld;
  logic [1:0] n_sel0, n_sel1;

  function automatic logic [31:0] enc(input logic [6:0] op, input int rd, input int rs1,
                                      input int rs2, input int f3);
    return {7'd0, 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic vec_t mk(input int r, input logic [31:0] ins, input int v, input int redir,
                              input int s1, input int s2, input int pc, input int st,
                              input int bub, input int fl);
    vec_t t;
    t.r = (r != 0); t.ins = ins; t.v = (v != 0); t.redir = (redir != 0);
    t.s1 = 2'(s1); t.s2 = 2'(s2);
    t.pc = (pc != 0); t.st = (st != 0); t.bub = (bub != 0); t.fl = (fl != 0);
    return t;
  endfunction

  function automatic void decode(input logic [31:0] ins, output int dst, output bit ld,
                                 output int a, output int b);
    int r1, r2, rdi;
    bit w;
    r1 = int'(ins[19:15]); r2 = int'(ins[24:20]); rdi = int'(ins[11:7]);
    w = 1'b0; a = -1; b = -1; ld = 1'b0;
    case (ins[6:0])
      7'h37, 7'h17, 7'h6f: w = 1'b1;
      7'h67, 7'h13:        begin w = 1'b1; a = r1; end
      7'h03:               begin w = 1'b1; a = r1; ld = 1'b1; end
      7'h63, 7'h23:        begin a = r1; b = r2; end
      7'h33:               begin w = 1'b1; a = r1; b = r2; end
      7'h73:               begin w = 1'b1; if (!ins[14]) a = r1; end
      default: ;
    endcase
    dst = (w && rdi != 0) ? rdi : -1;
  endfunction

  function automatic logic [1:0] pick(input int src, input int d2, input int d3, input int mode);
    if (src <= 0)  return 2'd2;
    if (src == d2) return 2'd0;
    if (src == d3) return (mode == 2) ? 2'd0 : 2'd1;
    return 2'd2;
  endfunction

  task automatic model_eval(input logic [31:0] ins, input bit v, input bit redir);
    int a, b;
    decode(ins, c_dst, c_ld, a, b);
    if (!v) begin c_dst = -1; c_ld = 1'b0; a = -1; b = -1; end
    e_hz = !FWD && m_l2 && ((a > 0 && a == m_d2) || (b > 0 && b == m_d2));
    e_pc = 1'b0; e_st = 1'b0; e_bub = 1'b0; e_fl = 1'b0;
    if (m_mode == 0) e_bub = 1'b1;
    else if (redir) begin e_fl = 1'b1; e_bub = 1'b1; end
    else if (m_mode == 1 && e_hz) begin e_pc = 1'b1; e_st = 1'b1; e_bub = 1'b1; end
    n_sel0 = pick(a, m_d2, m_d3, m_mode);
    n_sel1 = pick(b, m_d2, m_d3, m_mode);
  endtask

  task automatic model_commit(input bit r, input bit redir);
    if (!r) begin
      m_mode = 0; m_d2 = -1; m_d3 = -1; m_l2 = 1'b0; m_sel0 = 2'd2; m_sel1 = 2'd2;
    end else begin
      m_d3 = m_d2;
      if (e_bub) begin m_d2 = -1; m_l2 = 1'b0; end
      else begin m_d2 = c_dst; m_l2 = c_ld; end
      if (m_mode == 0 || redir) begin m_sel0 = 2'd2; m_sel1 = 2'd2; end
      else if (!e_st) begin m_sel0 = n_sel0; m_sel1 = n_sel1; end
      m_mode = (m_mode == 1 && !redir && e_hz) ? 2 : 1;
    end
  endtask

  task automatic chk2(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  // Drive inputs, sample at the falling edge, then let the model and DUT take the edge
  task automatic apply(input bit r, input logic [31:0] ins, input bit v, input bit redir);
    rst = r; inst_s1 = ins; s1_valid = v; redirect_s2 = redir;
    @(negedge clk);
    model_eval(ins, v, redir);
  endtask

  task automatic advance();
    model_commit(rst, redirect_s2);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] op;
    case ($urandom_range(0, 10))
      0: op = 7'h37;  1: op = 7'h17;  2: op = 7'h6f;  3: op = 7'h67;
      4: op = 7'h63;  5: op = 7'h03;  6: op = 7'h23;  7: op = 7'h13;
      8: op = 7'h33;  9: op = 7'h73;  default: op = 7'h0f;
    endcase
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), op};
  endfunction

  initial begin
    logic [31:0] addi5, add6, nop_i, sub7, addi0, add1, lw8, add9;
    logic [31:0] lw10, add11, add12, lw13, add14, add15, rins;
    bit          hold, rr, rd_r, rv;

    addi5 = enc(7'h13, 5, 0, 1, 0);
    add6  = enc(7'h33, 6, 5, 5, 0);
    nop_i = enc(7'h13, 0, 0, 0, 0);
    sub7  = enc(7'h33, 7, 5, 1, 0);
    addi0 = enc(7'h13, 0, 0, 5, 0);
    add1  = enc(7'h33, 1, 0, 0, 0);
    lw8   = enc(7'h03, 8, 1, 0, 2);
    add9  = enc(7'h33, 9, 8, 2, 0);
    lw10  = enc(7'h03, 10, 0, 0, 2);
    add11 = enc(7'h33, 11, 10, 10, 0);
    add12 = enc(7'h33, 12, 11, 10, 0);
    lw13  = enc(7'h03, 13, 0, 0, 2);
    add14 = enc(7'h33, 14, 13, 0, 0);
    add15 = enc(7'h33, 15, 13, 14, 0);

    //              r  ins    v  rd s1 s2 pc st bub fl
    tbl.push_back(mk(0, 0,     0, 0, 2, 2, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0,     0, 0, 2, 2, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0,     0, 0, 2, 2, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0,     0, 0, 2, 2, 0, 0, 1, 0));
    tbl.push_back(mk(1, addi5, 1, 0, 2, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, add6,  1, 0, 2, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0,     0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, addi5, 1, 0, 2, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, nop_i, 1, 0, 2, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, sub7,  1, 0, 2, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, addi0, 1, 0, 1, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, add1,  1, 0, 2, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, lw8,   1, 0, 2, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, add9,  1, 0, 0, 2, FWD ? 0 : 1, FWD ? 0 : 1, FWD ? 0 : 1, 0));
    tbl.push_back(mk(1, FWD ? 32'd0 : add9, FWD ? 0 : 1, 0, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0,     0, 0, FWD ? 2 : 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, lw10,  1, 0, 2, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, add11, 1, 1, 2, 2, 0, 0, 1, 1));
    tbl.push_back(mk(1, add12, 1, 0, 2, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0,     0, 0, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, lw13,  1, 0, 2, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, add14, 1, 0, 2, 2, FWD ? 0 : 1, FWD ? 0 : 1, FWD ? 0 : 1, 0));
    tbl.push_back(mk(0, add14, 1, 0, FWD ? 0 : 2, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0,     0, 0, 2, 2, 0, 0, 1, 0));
    tbl.push_back(mk(1, add15, 1, 0, 2, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0,     0, 0, 2, 2, 0, 0, 0, 0));

    // One reset edge before the table so the first row sees a defined state
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].ins, tbl[i].v, tbl[i].redir);
      chk2($sformatf("row%0d rs1_sel", i), rs1_sel, tbl[i].s1);
      chk2($sformatf("row%0d rs2_sel", i), rs2_sel, tbl[i].s2);
      chk1($sformatf("row%0d pc_stall", i), pc_stall, tbl[i].pc);
      chk1($sformatf("row%0d s1_stall", i), s1_stall, tbl[i].st);
      chk1($sformatf("row%0d s2_bubble", i), s2_bubble, tbl[i].bub);
      chk1($sformatf("row%0d s1_flush", i), s1_flush, tbl[i].fl);
      advance();
    end

    hold = 1'b0;
    rins = '0;
    rv   = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        rins = rand_inst();
        rv   = ($urandom_range(0, 7) != 0);
      end
      rr   = ($urandom_range(0, 99) != 0);
      rd_r = ($urandom_range(0, 9) == 0);
      apply(rr, rins, rv, rd_r);
      chk2("rnd rs1_sel", rs1_sel, m_sel0);
      chk2("rnd rs2_sel", rs2_sel, m_sel1);
      chk1("rnd pc_stall", pc_stall, e_pc);
      chk1("rnd s1_stall", s1_stall, e_st);
      chk1("rnd s2_bubble", s2_bubble, e_bub);
      chk1("rnd s1_flush", s1_flush, e_fl);
      hold = e_st && rr;
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
